// File: rtl/soc_ram_arbiter.sv
// soc_ram_arbiter: two-master round-robin arbiter in front of a single-port
// on-chip RAM. At most one transfer is issued per clock. Read data comes back
// one clock later and is steered to the master that issued the read. The
// arbiter limits how many consecutive grants one master can take while the
// other master is waiting.
module soc_ram_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    // master 0
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    // master 1
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    // RAM port
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

    // Arbitration and read-return state
    logic             owner_reg, owner_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic             rd_pend_reg, rd_pend_next;
    logic             rd_tag_reg, rd_tag_next;

    // Per-master request view, indexed by master number
    logic [1:0] rd_in;
    logic [1:0] wr_in;
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] wait_vec;
    logic [1:0] valid_vec;

    logic       grant_any;
    logic       winner;
    logic       win_write;

    assign rd_in = {m1_read, m0_read};
    assign wr_in = {m1_write, m0_write};

    // Per-master request, stall and read-valid decode. Stall is forced high
    // during reset; a read returning in the reset cycle is dropped.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign req[gi]       = rd_in[gi] | wr_in[gi];
            assign wait_vec[gi]  = reset | (req[gi] & ~grant[gi]);
            assign valid_vec[gi] = rd_pend_reg & (rd_tag_reg == 1'(gi)) & ~reset;
        end
    endgenerate

    // Winner selection: single requester wins outright; under contention the
    // owner keeps the RAM until it has used up its hold budget.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (req[0] && req[1]) begin
                if (hold_cnt_reg < HOLD_MAX) begin
                    grant[owner_reg] = 1'b1;
                end else begin
                    grant[~owner_reg] = 1'b1;
                end
            end else if (req[0]) begin
                grant[0] = 1'b1;
            end else if (req[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

    assign grant_any = |grant;
    // With no grant this selects master 0, which is what the idle RAM port shows.
    assign winner    = grant[1];
    // Read and write both high on one master counts as a write.
    assign win_write = winner ? m1_write : m0_write;

    // Next-state for owner/hold counter and the read-return tracker
    always_comb begin
        owner_next    = owner_reg;
        hold_cnt_next = hold_cnt_reg;
        rd_pend_next  = 1'b0;
        rd_tag_next   = rd_tag_reg;
        if (grant_any) begin
            if (winner == owner_reg) begin
                if (hold_cnt_reg != HOLD_MAX) begin
                    hold_cnt_next = hold_cnt_reg + HOLD_ONE;
                end
            end else begin
                owner_next    = winner;
                hold_cnt_next = HOLD_ONE;
            end
            if (!win_write) begin
                rd_pend_next = 1'b1;
                rd_tag_next  = winner;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_reg    <= 1'b0;
            hold_cnt_reg <= '0;
            rd_pend_reg  <= 1'b0;
            rd_tag_reg   <= 1'b0;
        end else begin
            owner_reg    <= owner_next;
            hold_cnt_reg <= hold_cnt_next;
            rd_pend_reg  <= rd_pend_next;
            rd_tag_reg   <= rd_tag_next;
        end
    end

    // RAM port mux: reads use a full byte mask, idle cycles show master 0 values
    always_comb begin
        ram_chipselect = grant_any;
        ram_write      = grant_any & win_write;
        ram_address    = winner ? m1_address   : m0_address;
        ram_writedata  = winner ? m1_writedata : m0_writedata;
        if (grant_any && !win_write) begin
            ram_byteenable = {BE_W{1'b1}};
        end else begin
            ram_byteenable = winner ? m1_byteenable : m0_byteenable;
        end
    end

    assign ram_clken        = ~reset;
    assign m0_waitrequest   = wait_vec[0];
    assign m1_waitrequest   = wait_vec[1];
    assign m0_readdatavalid = valid_vec[0];
    assign m1_readdatavalid = valid_vec[1];
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_soc_ram_arbiter.sv
// Testbench for soc_ram_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model and a
// behavioural RAM.
module tb_soc_ram_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] a0, a1;
    logic [3:0]  be0, be1;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] wd0, wd1;

    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] ref_mem [0:4095];
    int          m_owner;
    int          m_hold;
    bit          m_pend;
    int          m_tag;
    logic [31:0] m_data;

    // values captured from the last cycle
    logic        last_wait0, last_wait1, last_v1;
    logic [31:0] cap0, cap1;

    // behavioural RAM
    logic [31:0] ram_mem [0:4095];

    always #5 clk = ~clk;

    soc_ram_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(rst),
        .m0_address(a0), .m0_byteenable(be0), .m0_read(rd0), .m0_write(wr0),
        .m0_writedata(wd0), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(a1), .m1_byteenable(be1), .m1_read(rd1), .m1_write(wr1),
        .m1_writedata(wd1), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
    );

    always @(posedge clk) begin
        if (ram_chipselect && ram_clken) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
            end else begin
                ram_readdata <= ram_mem[ram_address];
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance both.
    task automatic tick();
        bit r0, r1, g, is_wr, w;
        logic [11:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd, merged;
        @(negedge clk);
        r0 = rd0 | wr0;
        r1 = rd1 | wr1;
        g = 1'b0;
        w = 1'b0;
        if (!rst) begin
            if (r0 && r1) begin
                g = 1'b1;
                w = (m_hold < MAX_HOLD) ? (m_owner == 1) : (m_owner == 0);
            end else if (r0) begin
                g = 1'b1;
            end else if (r1) begin
                g = 1'b1;
                w = 1'b1;
            end
        end
        is_wr  = w ? wr1 : wr0;
        e_addr = (g && w) ? a1 : a0;
        e_wd   = (g && w) ? wd1 : wd0;
        e_be   = !g ? be0 : (!is_wr ? 4'hF : (w ? be1 : be0));
        chk_eq("wait0", 32'(m0_waitrequest), 32'(rst | (r0 & ~(g & ~w))));
        chk_eq("wait1", 32'(m1_waitrequest), 32'(rst | (r1 & ~(g & w))));
        chk_eq("chipselect", 32'(ram_chipselect), 32'(g));
        chk_eq("ram_write", 32'(ram_write), 32'(g & is_wr));
        chk_eq("ram_address", 32'(ram_address), 32'(e_addr));
        chk_eq("ram_byteenable", 32'(ram_byteenable), 32'(e_be));
        chk_eq("ram_writedata", ram_writedata, e_wd);
        chk_eq("clken", 32'(ram_clken), 32'(!rst));
        chk_eq("rdvalid0", 32'(m0_readdatavalid), 32'(!rst && m_pend && m_tag == 0));
        chk_eq("rdvalid1", 32'(m1_readdatavalid), 32'(!rst && m_pend && m_tag == 1));
        if (!rst && m_pend) begin
            if (m_tag == 0) chk_eq("rdata0", m0_readdata, m_data);
            else            chk_eq("rdata1", m1_readdata, m_data);
        end
        last_wait0 = m0_waitrequest;
        last_wait1 = m1_waitrequest;
        last_v1    = m1_readdatavalid;
        if (m0_readdatavalid) cap0 = m0_readdata;
        if (m1_readdatavalid) cap1 = m1_readdata;
        @(posedge clk);
        if (rst) begin
            m_owner = 0;
            m_hold  = 0;
            m_pend  = 1'b0;
        end else begin
            m_pend = g && !is_wr;
            if (g) begin
                if (int'(w) == m_owner) begin
                    if (m_hold < MAX_HOLD) m_hold++;
                end else begin
                    m_owner = int'(w);
                    m_hold  = 1;
                end
                if (is_wr) begin
                    merged = ref_mem[e_addr];
                    for (int b = 0; b < 4; b++)
                        if (e_be[b]) merged[b*8 +: 8] = e_wd[b*8 +: 8];
                    ref_mem[e_addr] = merged;
                end else begin
                    m_data = ref_mem[e_addr];
                    m_tag  = int'(w);
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    endtask

    task automatic m0_op(input bit is_w, input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
        rd0 = !is_w; wr0 = is_w; a0 = a; be0 = be; wd0 = d;
    endtask

    task automatic do_reset(input int cycles);
        idle();
        rst = 1;
        for (int i = 0; i < cycles; i++) tick();
        rst = 0;
    endtask

    initial begin
        int waits;
        bit granted;
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        m_owner = 0; m_hold = 0; m_pend = 0; m_tag = 0; m_data = '0;
        a0 = '0; a1 = '0; be0 = '0; be1 = '0; wd0 = '0; wd1 = '0;
        cap0 = '0; cap1 = '0;
        idle();
        rst = 1;
        #1;
        do_reset(2);

        // preload the random-traffic window through the arbiter
        for (int i = 0; i < 16; i++) begin
            m0_op(1, 12'(i), 4'hF, 32'h0);
            tick();
        end

        // single master write then read
        m0_op(1, 12'h010, 4'hF, 32'hDEADBEEF); tick();
        chk_eq("single_wr_wait", 32'(last_wait0), 32'h0);
        m0_op(0, 12'h010, 4'h0, 32'h0); tick();
        chk_eq("single_rd_wait", 32'(last_wait0), 32'h0);
        idle(); tick();
        chk_eq("single_rd_data", cap0, 32'hDEADBEEF);

        // byte enables at the top address
        m0_op(1, 12'hFFF, 4'hF, 32'h11223344); tick();
        m0_op(1, 12'hFFF, 4'b0101, 32'hAABBCCDD); tick();
        m0_op(0, 12'hFFF, 4'h0, 32'h0); tick();
        idle(); tick();
        chk_eq("byteenable_merge", cap0, 32'h11BB33DD);

        // simultaneous write (m0, owner) and read (m1) of one address
        do_reset(1);
        m0_op(1, 12'h020, 4'hF, 32'h5);
        rd1 = 1; a1 = 12'h020;
        tick();
        chk_eq("simul_m1_waits", 32'(last_wait1), 32'h1);
        wr0 = 0; tick();
        chk_eq("simul_m1_granted", 32'(last_wait1), 32'h0);
        idle(); tick();
        chk_eq("simul_rd_data", cap1, 32'h5);

        // continuous contention from reset: m0 x4, m1 x4, ...
        do_reset(1);
        rd0 = 1; a0 = 12'h010; rd1 = 1; a1 = 12'hFFF;
        for (int i = 0; i < 24; i++) begin
            tick();
            chk_eq("contend_pattern", 32'(last_wait0), 32'((i / MAX_HOLD) % 2));
        end

        // starvation bound: m1 owner first, then m0 streams, m1 asks once
        do_reset(1);
        rd1 = 1; a1 = 12'h001; tick();
        rd1 = 0; rd0 = 1; a0 = 12'h002; tick();
        rd1 = 1;
        waits = 0;
        granted = 0;
        for (int i = 0; i < 12 && !granted; i++) begin
            tick();
            if (last_wait1) waits++;
            else granted = 1;
        end
        rd1 = 0;
        chk_eq("starve_granted", 32'(granted), 32'h1);
        chk_eq("starve_within_bound", 32'(waits <= MAX_HOLD), 32'h1);
        idle(); tick();

        // reset the cycle after an m1 read grant
        do_reset(1);
        rd1 = 1; a1 = 12'h010; tick();
        rd1 = 0; rst = 1; tick();
        chk_eq("rst_drop_valid1", 32'(last_v1), 32'h0);
        chk_eq("rst_wait1", 32'(last_wait1), 32'h1);
        tick();
        rst = 0;
        rd0 = 1; a0 = 12'h003; rd1 = 1; a1 = 12'h004; tick();
        chk_eq("rst_owner_m0", 32'(last_wait0), 32'h0);
        chk_eq("rst_owner_m1_waits", 32'(last_wait1), 32'h1);
        idle(); tick();

        // randomized traffic over a small address window
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            rd0 = ($urandom_range(0, 2) != 0); wr0 = ($urandom_range(0, 3) == 0);
            rd1 = ($urandom_range(0, 2) != 0); wr1 = ($urandom_range(0, 3) == 0);
            a0 = 12'($urandom_range(0, 15)); a1 = 12'($urandom_range(0, 15));
            be0 = 4'($urandom); be1 = 4'($urandom);
            wd0 = $urandom; wd1 = $urandom;
            tick();
        end
        rst = 0;
        idle(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
